// File: rtl/dm_responder.sv
// Handshaked 4 KB data-memory responder: one request at a time, completes after
// LATENCY wait states with a single-cycle ack. Reset clears the whole array.
module dm_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [9:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem_q [0:DEPTH-1];

    logic        enter_resp;
    logic        xn_we;
    logic [9:0]  xn_addr;
    logic [31:0] xn_wdata;
    logic [3:0]  xn_be;
    logic        mem_we;
    logic [31:0] mem_wword;

    // With zero latency the commit happens on the accept edge, so the live
    // inputs govern the transaction instead of the latched copies.
    always_comb begin
        xn_we    = we_q;
        xn_addr  = addr_q;
        xn_wdata = wdata_q;
        xn_be    = be_q;
        if (state_q == S_IDLE) begin
            xn_we    = we;
            xn_addr  = addr;
            xn_wdata = wdata;
            xn_be    = be;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    if (LATENCY == 0) begin
                        enter_resp = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack_d     = enter_resp;
        busy_d    = (state_d != S_IDLE);
        rdata_d   = '0;
        mem_we    = enter_resp & xn_we;
        mem_wword = mem_q[xn_addr];
        for (int i = 0; i < 4; i++) begin
            if (xn_be[i]) begin
                mem_wword[8*i +: 8] = xn_wdata[8*i +: 8];
            end
        end
        if (enter_resp && !xn_we) begin
            rdata_d = mem_q[xn_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            if (mem_we) begin
                mem_q[xn_addr] <= mem_wword;
            end
        end
    end

    assign ack   = ack_q;
    assign busy  = busy_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboarded bench for dm_responder: one instance with LATENCY=2, one with LATENCY=0.
module tb_dm_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req2, we2, ack2, busy2;
    logic [9:0]  addr2;
    logic [31:0] wdata2, rdata2;
    logic [3:0]  be2;
    logic        req0, we0, ack0, busy0;
    logic [9:0]  addr0;
    logic [31:0] wdata0, rdata0;
    logic [3:0]  be0;

    dm_responder #(.LATENCY(2), .DEPTH(1024)) u_dut2 (
        .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2),
        .wdata(wdata2), .be(be2), .rdata(rdata2), .ack(ack2), .busy(busy2)
    );

    dm_responder #(.LATENCY(0), .DEPTH(1024)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .be(be0), .rdata(rdata0), .ack(ack0), .busy(busy0)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp2_q[$];
    logic [31:0] exp0_q[$];
    logic [31:0] model2 [1024];
    logic [31:0] model0 [1024];
    logic [31:0] last_rd2;
    time         ack_t2;
    time         t_a;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard pop side: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ack2 === 1'b1) begin
            ack_t2   = $time;
            last_rd2 = rdata2;
            if (exp2_q.size() == 0) check_val("ack2_spurious", 32'(ack2), 32'd0);
            else check_val("rdata2", rdata2, exp2_q.pop_front());
        end
        if (ack0 === 1'b1) begin
            if (exp0_q.size() == 0) check_val("ack0_spurious", 32'(ack0), 32'd0);
            else check_val("rdata0", rdata0, exp0_q.pop_front());
        end
    end

    task automatic clear_models();
        for (int i = 0; i < 1024; i++) begin
            model2[i] = '0;
            model0[i] = '0;
        end
    endtask

    task automatic start2(input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
        req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d; be2 = b;
        if (w) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) model2[a][8*i +: 8] = d[8*i +: 8];
            exp2_q.push_back(32'd0);
        end else begin
            exp2_q.push_back(model2[a]);
        end
    endtask

    task automatic finish2();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (ack2 === 1'b1) seen = 1'b1;
        end
        if (!seen) check_val("ack2_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req2 = 1'b0;
    endtask

    task automatic txn2(input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
        start2(w, a, d, b);
        finish2();
    endtask

    initial begin
        reset = 1'b1;
        req2 = 0; we2 = 0; addr2 = '0; wdata2 = '0; be2 = '0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; be0 = '0;
        last_rd2 = '0; ack_t2 = 0;
        clear_models();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ack2", 32'(ack2), 32'd0);
        check_val("rst_busy2", 32'(busy2), 32'd0);
        check_val("rst_rdata2", rdata2, 32'd0);
        check_val("rst_ack0", 32'(ack0), 32'd0);
        check_val("rst_busy0", 32'(busy0), 32'd0);
        reset = 1'b0;

        // Load of word 0 after reset: ack only after edge 2, busy through edge 2.
        start2(1'b0, 10'h000, 32'd0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) req2 = 1'b0;
            check_val($sformatf("t1_ack_e%0d", k), 32'(ack2), 32'(k == 2));
            check_val($sformatf("t1_busy_e%0d", k), 32'(busy2), 32'(k < 3));
            if (k >= 2) check_val($sformatf("t1_rdata_e%0d", k), rdata2, 32'd0);
        end

        // Full-word store/load at the top word, acks spaced LATENCY+2 edges.
        txn2(1'b1, 10'h3FF, 32'hDEADBEEF, 4'hF);
        t_a = ack_t2;
        txn2(1'b0, 10'h3FF, 32'd0, 4'h0);
        check_val("t2_spacing", 32'(ack_t2 - t_a), 32'd40);
        check_val("t2_data", last_rd2, 32'hDEADBEEF);

        // Byte-enable merge, then an all-disabled store.
        txn2(1'b1, 10'h010, 32'h11223344, 4'hF);
        txn2(1'b1, 10'h010, 32'hAABBCCDD, 4'b0101);
        txn2(1'b0, 10'h010, 32'd0, 4'h0);
        check_val("t3_partial", last_rd2, 32'h11BB33DD);
        txn2(1'b1, 10'h010, 32'hFFFFFFFF, 4'b0000);
        txn2(1'b0, 10'h010, 32'd0, 4'h0);
        check_val("t3_be0", last_rd2, 32'h11BB33DD);

        // Inputs changed during WAIT must not affect the accepted store.
        start2(1'b1, 10'h020, 32'h12345678, 4'hF);
        @(posedge clk);
        #1 addr2 = 10'h021; wdata2 = 32'hFFFFFFFF;
        finish2();
        txn2(1'b0, 10'h020, 32'd0, 4'h0);
        check_val("t5_kept", last_rd2, 32'h12345678);
        txn2(1'b0, 10'h021, 32'd0, 4'h0);

        // LATENCY=0 with req held high: store/load alternate, ack every 2nd edge.
        req0 = 1'b1; addr0 = 10'h005; wdata0 = 32'h00000007; be0 = 4'hF;
        for (int i = 0; i < 6; i++) begin
            we0 = (i % 2 == 0);
            if (we0) begin
                model0[5] = 32'h00000007;
                exp0_q.push_back(32'd0);
            end else begin
                exp0_q.push_back(model0[5]);
            end
            @(posedge clk);
            #1;
            check_val($sformatf("t4_ack_acc%0d", i), 32'(ack0), 32'd1);
            check_val($sformatf("t4_busy_acc%0d", i), 32'(busy0), 32'd1);
            @(posedge clk);
            #1;
            check_val($sformatf("t4_ack_idle%0d", i), 32'(ack0), 32'd0);
        end
        req0 = 1'b0;

        // Reset mid-WAIT discards the store; reset also beats a simultaneous req.
        req2 = 1'b1; we2 = 1'b1; addr2 = 10'h030; wdata2 = 32'h5A5A5A5A; be2 = 4'hF;
        @(posedge clk);
        #1;
        check_val("t6_busy_wait", 32'(busy2), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("t6_ack_rst", 32'(ack2), 32'd0);
        check_val("t6_busy_rst", 32'(busy2), 32'd0);
        @(posedge clk);
        #1;
        check_val("t6_rst_beats_req", 32'(busy2), 32'd0);
        reset = 1'b0;
        req2 = 1'b0;
        clear_models();
        repeat (3) @(posedge clk);
        #1;
        txn2(1'b0, 10'h030, 32'd0, 4'h0);
        txn2(1'b0, 10'h3FF, 32'd0, 4'h0);
        txn2(1'b0, 10'h010, 32'd0, 4'h0);

        repeat (3) @(posedge clk);
        check_val("sb2_drain", 32'(exp2_q.size()), 32'd0);
        check_val("sb0_drain", 32'(exp0_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
# dm_responder

Handshaked data-memory responder serving the load/store port of the MIPS datapath. It holds 4 KB of word storage (`addr[11:2]`) and accepts one request at a time from the CPU-side initiator. Each request completes after a programmable wait-state latency with a single-cycle `ack`. It replaces the zero-wait data memory when the core runs against a stalled memory model, and reset clears the storage exactly as the existing data memory does.

## Interface
Parameters:
- `LATENCY`, 2: wait states between request acceptance and `ack`; legal range 0..15.
- `DEPTH`, 1024: number of 32-bit words; address width is fixed at 10 bits (`addr[11:2]`).

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  request valid; held by the initiator until it sees `ack`.
- `we`  in  1  1 = store, 0 = load; sampled with `req`.
- `addr`  in  10  word address `[11:2]`; sampled with `req`.
- `wdata`  in  32  store data; sampled with `req`.
- `be`  in  4  byte enables for stores (bit i controls `wdata[8i+7:8i]`); ignored for loads.
- `rdata`  out  32  load data, valid only while `ack`=1.
- `ack`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while a request is in flight (WAIT or RESP).

## Operation
- States: IDLE, WAIT, RESP. Registered outputs: `ack`, `rdata`, `busy`.
- IDLE: `req`=1 at a rising edge accepts the request and latches `we`/`addr`/`wdata`/`be`.
  - If `LATENCY`>0: go to WAIT with the counter loaded to `LATENCY`-1.
  - If `LATENCY`=0: go directly to RESP.
- WAIT: the counter decrements each edge. At the edge where the counter is 0, go to RESP.
- Entry to RESP (same edge):
  - Store: merge enabled bytes into `mem[addr]`.
  - Load: `rdata` <= `mem[addr]`.
  - `ack` <= 1.
- RESP: always returns to IDLE at the next edge, with `ack` <= 0 and `rdata` <= 0.
- Store with `be`=4'b0000 completes normally (ack pulses) and leaves memory unchanged.
- Store in RESP: `rdata` is 0.
- `req`, `addr`, `wdata`, `we` and `be` while in WAIT or RESP are ignored (no queuing). Latched values govern the transaction.
- Back-to-back: if `req` is still 1 in the IDLE cycle after RESP, it is accepted as a new request. The initiator must drop `req` on the edge where it samples `ack`=1 unless it is issuing a new request.
- Read-after-write to the same address in consecutive transactions returns the newly written data.

## Timing
- Request sampled at edge n:
  - Store commits at edge n+`LATENCY`.
  - `ack` and `rdata` are high/valid for exactly the cycle between edges n+`LATENCY` and n+`LATENCY`+1.
- `busy` rises after edge n and falls after edge n+`LATENCY`+1. `busy`=0 implies IDLE.
- Minimum request-to-request spacing is `LATENCY`+2 edges.
- Reset (sync, any state, including mid-WAIT or RESP):
  - State goes to IDLE.
  - `ack`=0, `busy`=0, `rdata`=0, counter=0.
  - All `DEPTH` words cleared to 0.
  - A pending store that has not reached its commit edge is discarded.
  - `reset` and `req` high at the same edge: reset wins and the request is not accepted.
- Address wrap: `addr` is exactly 10 bits. Word 1023 is valid and there is no out-of-range case.

## Test plan
- Reset then load `addr`=0x000, `LATENCY`=2: `req` at edge 0 -> `ack`=1 and `rdata`=0x00000000 in cycle 2-3 only; `busy` high cycles 0-3.
- Store `addr`=0x3FF, `wdata`=0xDEADBEEF, `be`=4'hF, then load 0x3FF -> `rdata`=0xDEADBEEF; `ack` pulses once per transaction, spaced 4 edges.
- Partial store: word 0x010 = 0x11223344, store `wdata`=0xAABBCCDD with `be`=4'b0101 -> load returns 0x11BB33DD. A store with `be`=0 leaves 0x11BB33DD.
- `LATENCY`=0, `req` held high continuously with alternating store/load of 0x005 = 0x00000007 -> `ack` every 2nd cycle, load returns 0x00000007.
- Changing `addr`/`wdata` during WAIT (accepted 0x020/0x12345678, switched to 0x021/0xFFFFFFFF) -> only 0x020 written with 0x12345678; 0x021 stays 0.
- `reset` asserted during WAIT of store 0x030 = 0x5A5A5A5A -> no `ack`, `busy`=0 next cycle, and a later load of 0x030 returns 0.
